// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS run controller:
//     - run_state_e : run-controller state encoding (3 bits)
//     - DEF_PC_W    : default program counter width
//     - DEF_CNT_W   : default cycle / retire counter width
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int DEF_PC_W  = 32;
   localparam int DEF_CNT_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HOLD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_DONE    = 3'd3,
      ST_TIMEOUT = 3'd4
   } run_state_e;

endpackage : mips_pkg

// File: rtl/mips_run_controller_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter with synchronous clear and enable that sticks at all-ones.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset (count -> 0)
//     clr   : synchronous clear; when en is also high the counter restarts
//             at 1 (clear-and-count-this-cycle)
//     en    : count enable
//     count : registered count value
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         // clr+en means "this event starts a fresh run of length 1"
         count_d = en ? W'(1) : '0;
      end else if (en && !(&count_q)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/mips_run_controller.sv
// -----------------------------------------------------------------------------
// mips_run_controller
//   Reset sequencer, cycle budget and halt-loop detector for the MIPS core.
//   Ports:
//     clk          : system clock, rising edge
//     rst_n        : synchronous active-low reset
//     start        : one-cycle request to (re)launch a program run
//     core_pc      : PC of the instruction retiring this cycle
//     core_retire  : one instruction retires this cycle
//     core_rst_n   : synchronous active-low reset to the core
//     running      : high while in RUN
//     done         : sticky halt-detected flag
//     timeout      : sticky budget-exhausted flag
//     cycle_count  : RUN cycles elapsed
//     retire_count : instructions retired in RUN
//     halt_pc      : PC of the detected halt loop
//   All outputs are registered.
// -----------------------------------------------------------------------------
module mips_run_controller
   import mips_pkg::*;
#(
   parameter int PC_W        = DEF_PC_W,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int RESET_HOLD  = 4,
   parameter int MAX_CYCLES  = 10000,
   parameter int HALT_REPEAT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [PC_W-1:0]  core_pc,
   input  logic             core_retire,
   output logic             core_rst_n,
   output logic             running,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retire_count,
   output logic [PC_W-1:0]  halt_pc
);

   localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam int REP_W  = $clog2(HALT_REPEAT + 1);

   run_state_e       state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [PC_W-1:0]  last_pc_q, last_pc_d;
   logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             core_rst_n_q, core_rst_n_d;
   logic             running_q, running_d;

   logic [REP_W-1:0] rep_q;
   logic [REP_W-1:0] rep_upd;
   logic             in_run;
   logic             retire_run;
   logic             pc_match;
   logic             cyc_en;
   logic             rep_clr;
   logic             halt_hit;
   logic             budget_hit;

   // start takes priority over everything else in every state, so a start
   // cycle never counts as a RUN cycle or a retirement.
   assign in_run     = (state_q == ST_RUN);
   assign cyc_en     = in_run && !start;
   assign retire_run = cyc_en && core_retire;
   assign pc_match   = (core_pc == last_pc_q);
   assign rep_clr    = start || (retire_run && !pc_match);

   // Value the repeat counter will hold after this cycle's retirement;
   // mirrors the sat_counter update so the halt decision is made this cycle.
   assign rep_upd    = pc_match ? ((&rep_q) ? rep_q : rep_q + 1'b1) : REP_W'(1);
   assign halt_hit   = retire_run && (rep_upd == REP_W'(HALT_REPEAT));
   assign budget_hit = cyc_en && (cycle_count == CNT_W'(MAX_CYCLES - 1));

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .en    (cyc_en),
      .count (cycle_count)
   );

   sat_counter #(.W(CNT_W)) u_retire_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .en    (retire_run),
      .count (retire_count)
   );

   sat_counter #(.W(REP_W)) u_repeat_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (rep_clr),
      .en    (retire_run),
      .count (rep_q)
   );

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      last_pc_d = last_pc_q;
      halt_pc_d = halt_pc_q;
      done_d    = done_q;
      timeout_d = timeout_q;

      if (start) begin
         state_d   = ST_HOLD;
         hold_d    = HOLD_W'(RESET_HOLD - 1);
         last_pc_d = '0;
         halt_pc_d = '0;
         done_d    = 1'b0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_HOLD: begin
               if (hold_q == '0) begin
                  state_d = ST_RUN;
               end else begin
                  hold_d = hold_q - 1'b1;
               end
            end
            ST_RUN: begin
               if (core_retire) begin
                  last_pc_d = core_pc;
               end
               // Halt has priority when both land on the same cycle.
               if (halt_hit) begin
                  state_d   = ST_DONE;
                  done_d    = 1'b1;
                  halt_pc_d = core_pc;
               end else if (budget_hit) begin
                  state_d   = ST_TIMEOUT;
                  timeout_d = 1'b1;
               end
            end
            ST_DONE, ST_TIMEOUT: begin
               state_d = state_q;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Registered from the next state so the core sees the change on the
      // same edge as the state transition.
      core_rst_n_d = (state_d == ST_RUN);
      running_d    = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         hold_q       <= '0;
         last_pc_q    <= '0;
         halt_pc_q    <= '0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         core_rst_n_q <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         last_pc_q    <= last_pc_d;
         halt_pc_q    <= halt_pc_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         core_rst_n_q <= core_rst_n_d;
         running_q    <= running_d;
      end
   end

   assign core_rst_n = core_rst_n_q;
   assign running    = running_q;
   assign done       = done_q;
   assign timeout    = timeout_q;
   assign halt_pc    = halt_pc_q;

endmodule : mips_run_controller

// File: tb/tb_mips_run_controller.sv
// -----------------------------------------------------------------------------
// tb_mips_run_controller
//   Directed, table-driven bench for mips_run_controller with a short cycle
//   budget (MAX_CYCLES=20) so the timeout paths are reachable quickly.
// -----------------------------------------------------------------------------
module tb_mips_run_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] core_pc = '0;
   logic        core_retire = 1'b0;
   logic        core_rst_n;
   logic        running;
   logic        done;
   logic        timeout;
   logic [31:0] cycle_count;
   logic [31:0] retire_count;
   logic [31:0] halt_pc;

   int checks = 0;
   int errors = 0;

   mips_run_controller #(
      .PC_W        (32),
      .CNT_W       (32),
      .RESET_HOLD  (4),
      .MAX_CYCLES  (20),
      .HALT_REPEAT (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .core_pc      (core_pc),
      .core_retire  (core_retire),
      .core_rst_n   (core_rst_n),
      .running      (running),
      .done         (done),
      .timeout      (timeout),
      .cycle_count  (cycle_count),
      .retire_count (retire_count),
      .halt_pc      (halt_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        retire;
      logic [31:0] pc;
      logic        e_rst_n;
      logic        e_run;
      logic        e_done;
      logic        e_to;
      logic [31:0] e_cyc;
      logic [31:0] e_ret;
      logic [31:0] e_hpc;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_rst_n, input logic e_run,
                          input logic e_done, input logic e_to, input logic [31:0] e_cyc,
                          input logic [31:0] e_ret, input logic [31:0] e_hpc);
      chk({tag, ".core_rst_n"},   {31'b0, core_rst_n}, {31'b0, e_rst_n});
      chk({tag, ".running"},      {31'b0, running},    {31'b0, e_run});
      chk({tag, ".done"},         {31'b0, done},       {31'b0, e_done});
      chk({tag, ".timeout"},      {31'b0, timeout},    {31'b0, e_to});
      chk({tag, ".cycle_count"},  cycle_count,  e_cyc);
      chk({tag, ".retire_count"}, retire_count, e_ret);
      chk({tag, ".halt_pc"},      halt_pc,      e_hpc);
   endtask

   // Drive inputs for one clock, then sample 1 time unit after the edge.
   task automatic step(input logic s, input logic r, input logic [31:0] pc);
      start       = s;
      core_retire = r;
      core_pc     = pc;
      @(posedge clk);
      #1;
      start       = 1'b0;
      core_retire = 1'b0;
      $display("step start=%0b retire=%0b pc=%h -> rst_n=%0b run=%0b done=%0b to=%0b cyc=%0d ret=%0d hpc=%h",
               s, r, pc, core_rst_n, running, done, timeout, cycle_count, retire_count, halt_pc);
   endtask

   // Start pulse, then verify core reset stays low for exactly 4 cycles
   // and the run begins with fresh counters and cleared flags.
   task automatic launch(input string tag);
      step(1'b1, 1'b0, 32'h0);
      chk_all({tag, ".start"}, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'h0);
         chk({tag, ".hold_rst_n"}, {31'b0, core_rst_n}, 32'd0);
      end
      step(1'b0, 1'b0, 32'h0);
      chk({tag, ".run_rst_n"}, {31'b0, core_rst_n}, 32'd1);
      chk({tag, ".run_running"}, {31'b0, running}, 32'd1);
      chk({tag, ".run_cyc0"}, cycle_count, 32'd0);
   endtask

   initial begin
      //            start retire pc       rst_n run done to cyc ret hpc
      tbl[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0};
      tbl[1]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0};
      tbl[2]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0};
      tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0};
      tbl[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0};
      tbl[5]  = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 32'h0};
      tbl[6]  = '{1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 32'd2, 32'h0};
      tbl[7]  = '{1'b0, 1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd3, 32'h0};
      tbl[8]  = '{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b0, 1'b0, 32'd4, 32'd4, 32'h0};
      tbl[9]  = '{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 32'h0};
      tbl[10] = '{1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, 32'd6, 32'd6, 32'hC};
      tbl[11] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd6, 32'd6, 32'hC};

      // Reset for two cycles.
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0);
      rst_n = 1'b1;

      // Launch + halt loop at 0xC.
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].start, tbl[i].retire, tbl[i].pc);
         chk_all($sformatf("vec%0d", i), tbl[i].e_rst_n, tbl[i].e_run, tbl[i].e_done,
                 tbl[i].e_to, tbl[i].e_cyc, tbl[i].e_ret, tbl[i].e_hpc);
      end

      // Relaunch from DONE; retires interleaved with idle cycles.
      launch("relaunch");
      step(1'b0, 1'b1, 32'h10);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h10);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk_all("gap.pre", 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'd2, 32'h0);
      step(1'b0, 1'b1, 32'h10);
      chk_all("gap.halt", 1'b0, 1'b0, 1'b1, 1'b0, 32'd6, 32'd3, 32'h10);

      // Timeout with distinct PCs.
      launch("tmo");
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 1'b1, 32'h1000 + 32'(4 * i));
         if (i == 19) chk_all("tmo.pre", 1'b1, 1'b1, 1'b0, 1'b0, 32'd19, 32'd19, 32'h0);
      end
      chk_all("tmo.hit", 1'b0, 1'b0, 1'b0, 1'b1, 32'd20, 32'd20, 32'h0);
      step(1'b0, 1'b1, 32'h2000);
      chk_all("tmo.hold", 1'b0, 1'b0, 1'b0, 1'b1, 32'd20, 32'd20, 32'h0);

      // Third repeat lands on the budget-exhausting cycle: halt wins.
      launch("coll");
      for (int i = 1; i <= 17; i++) step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h40);
      step(1'b0, 1'b1, 32'h40);
      chk_all("coll.pre", 1'b1, 1'b1, 1'b0, 1'b0, 32'd19, 32'd2, 32'h0);
      step(1'b0, 1'b1, 32'h40);
      chk_all("coll.hit", 1'b0, 1'b0, 1'b1, 1'b0, 32'd20, 32'd3, 32'h40);

      // start mid-RUN at cycle_count=7 aborts and re-runs the hold sequence.
      launch("abort.first");
      for (int i = 1; i <= 7; i++) step(1'b0, 1'b1, 32'h200 + 32'(4 * i));
      chk_all("abort.pre", 1'b1, 1'b1, 1'b0, 1'b0, 32'd7, 32'd7, 32'h0);
      launch("abort.again");

      // rst_n low mid-RUN returns everything to reset values.
      step(1'b0, 1'b1, 32'h300);
      step(1'b0, 1'b1, 32'h304);
      chk_all("rst.pre", 1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 32'd2, 32'h0);
      rst_n = 1'b0;
      step(1'b0, 1'b1, 32'h308);
      chk_all("rst.hit", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0);
      rst_n = 1'b1;
      step(1'b0, 1'b1, 32'h30C);
      chk_all("rst.idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mips_run_controller
